// File: rtl/mine_pkg.sv
// Shared constants, state encoding and cell addressing for the 8x8 mine board.
package mine_pkg;

  localparam int ROWS    = 8;
  localparam int COLS    = 8;
  localparam int COORD_W = 3;
  localparam int COUNT_W = 4;
  localparam int TOTAL_W = 4;
  localparam int CELLS   = ROWS * COLS;
  localparam int IDX_W   = $clog2(CELLS);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PLACE = 2'd1,
    ST_COUNT = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  // Row-major flat index; with 8 columns this is just {row, col}.
  function automatic logic [IDX_W-1:0] cell_idx(input logic [COORD_W-1:0] row,
                                                input logic [COORD_W-1:0] col);
    return {row, col};
  endfunction

endpackage

// File: rtl/neighbor_counter.sv
// Purpose: count mines in the 3x3 window around one cell, centre excluded, no wrap.
// Latency: purely combinational.
// Backpressure: none; evaluates every cycle.
module neighbor_counter
  import mine_pkg::*;
(
  input  logic [CELLS-1:0]   mines,
  input  logic [COORD_W-1:0] row,
  input  logic [COORD_W-1:0] col,
  output logic [COUNT_W-1:0] count
);

  always_comb begin
    count = '0;
    for (int dr = -1; dr <= 1; dr++) begin
      for (int dc = -1; dc <= 1; dc++) begin
        // Off-board neighbours are skipped so edge cells never see the far side.
        if ((dr != 0 || dc != 0) &&
            (int'(row) + dr) >= 0 && (int'(row) + dr) < ROWS &&
            (int'(col) + dc) >= 0 && (int'(col) + dc) < COLS &&
            mines[IDX_W'((int'(row) + dr) * COLS + int'(col) + dc)])
          count = count + COUNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/mine_board.sv
// Purpose: place a requested number of unique mines, then build adjacency counts cell by cell.
// Latency: 1 cycle per accepted mine, 64 cycles of counting, queries registered (1 cycle).
// Backpressure: cand_ready only in PLACE; duplicates are consumed without effect.
module mine_board
  import mine_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [TOTAL_W-1:0] total_mines,
  input  logic               cand_valid,
  input  logic [COORD_W-1:0] cand_row,
  input  logic [COORD_W-1:0] cand_col,
  output logic               cand_ready,
  input  logic [COORD_W-1:0] query_row,
  input  logic [COORD_W-1:0] query_col,
  output logic               query_mine,
  output logic [COUNT_W-1:0] query_count,
  output logic [TOTAL_W-1:0] mines_placed,
  output logic               busy,
  output logic               done
);

  state_t             state;
  state_t             state_nxt;
  logic [CELLS-1:0]   mines;
  logic [COUNT_W-1:0] counts [CELLS];
  logic [TOTAL_W-1:0] total_lat;
  logic [IDX_W-1:0]   scan_idx;
  logic [COUNT_W-1:0] scan_count;
  logic [IDX_W-1:0]   cand_idx;
  logic [IDX_W-1:0]   query_idx;
  logic               start_ok;
  logic               cand_hs;
  logic               cand_new;
  logic               last_mine;
  logic               scan_last;

  assign cand_idx  = cell_idx(cand_row, cand_col);
  assign query_idx = cell_idx(query_row, query_col);

  // Handshake is derived from the state directly to keep it independent of the FSM output block.
  assign start_ok  = start && (state == ST_IDLE || state == ST_DONE);
  assign cand_hs   = cand_valid && (state == ST_PLACE);
  assign cand_new  = cand_hs && !mines[cand_idx];
  assign last_mine = cand_new && ((mines_placed + TOTAL_W'(1)) == total_lat);
  assign scan_last = (scan_idx == IDX_W'(CELLS - 1));

  neighbor_counter u_scan (
    .mines (mines),
    .row   (scan_idx[IDX_W-1:COORD_W]),
    .col   (scan_idx[COORD_W-1:0]),
    .count (scan_count)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    cand_ready = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    case (state)
      ST_IDLE, ST_DONE: begin
        done = (state == ST_DONE);
        if (start)
          state_nxt = (total_mines == '0) ? ST_COUNT : ST_PLACE;
      end
      ST_PLACE: begin
        cand_ready = 1'b1;
        busy       = 1'b1;
        if (last_mine) state_nxt = ST_COUNT;
      end
      ST_COUNT: begin
        busy = 1'b1;
        if (scan_last) state_nxt = ST_DONE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mines        <= '0;
      mines_placed <= '0;
      total_lat    <= '0;
      scan_idx     <= '0;
      query_mine   <= 1'b0;
      query_count  <= '0;
      for (int i = 0; i < CELLS; i++) counts[i] <= '0;
    end else begin
      query_mine  <= mines[query_idx];
      query_count <= counts[query_idx];
      if (start_ok) begin
        mines        <= '0;
        mines_placed <= '0;
        total_lat    <= total_mines;
        scan_idx     <= '0;
        for (int i = 0; i < CELLS; i++) counts[i] <= '0;
      end else begin
        if (cand_new) begin
          mines[cand_idx] <= 1'b1;
          if (mines_placed != total_lat) mines_placed <= mines_placed + TOTAL_W'(1);
        end
        // scan_idx wraps to 0 after the last cell, ready for the next game.
        if (state == ST_COUNT) begin
          counts[scan_idx] <= scan_count;
          scan_idx         <= scan_idx + IDX_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_mine_board.sv
// Scoreboard bench: driver pushes expectations from a padded-grid board model, monitor compares.
module tb_mine_board;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [3:0] total_mines;
  logic       cand_valid;
  logic [2:0] cand_row, cand_col;
  logic       cand_ready;
  logic [2:0] query_row, query_col;
  logic       query_mine;
  logic [3:0] query_count;
  logic [3:0] mines_placed;
  logic       busy, done;

  always #5 clk = ~clk;

  mine_board dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .total_mines  (total_mines),
    .cand_valid   (cand_valid),
    .cand_row     (cand_row),
    .cand_col     (cand_col),
    .cand_ready   (cand_ready),
    .query_row    (query_row),
    .query_col    (query_col),
    .query_mine   (query_mine),
    .query_count  (query_count),
    .mines_placed (mines_placed),
    .busy         (busy),
    .done         (done)
  );

  typedef struct packed {
    logic       mine;
    logic [3:0] count;
  } qexp_t;

  qexp_t q_exp[$];
  int    hs_exp[$];
  int    checks = 0;
  int    errors = 0;

  // Board with an empty one-cell margin: cell (r,c) lives at pad[r+1][c+1].
  bit    pad [0:9][0:9];
  int    ref_total, ref_placed;
  bit    ref_counted;

  logic  q_tag = 1'b0, q_vld_d = 1'b0, hs_d = 1'b0;

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  function automatic int ref_count(input int r, input int c);
    int s = 0;
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++)
        s += int'(pad[r+i][c+j]);
    return s - int'(pad[r+1][c+1]);
  endfunction

  task automatic clear_model();
    for (int i = 0; i < 10; i++)
      for (int j = 0; j < 10; j++)
        pad[i][j] = 1'b0;
    ref_placed  = 0;
    ref_counted = 1'b0;
  endtask

  // Monitor: shadow the query/handshake events by one edge and compare the registered outputs.
  always @(posedge clk) begin
    q_vld_d <= q_tag;
    hs_d    <= cand_valid && cand_ready && !rst;
  end

  always @(negedge clk) begin
    qexp_t e;
    if (q_vld_d) begin
      if (q_exp.size() == 0) check("query_underflow", 1, 0);
      else begin
        e = q_exp.pop_front();
        check("query_mine", int'(query_mine), int'(e.mine));
        check("query_count", int'(query_count), int'(e.count));
      end
    end
    if (hs_d) begin
      if (hs_exp.size() == 0) check("handshake_underflow", 1, 0);
      else check("mines_placed", int'(mines_placed), hs_exp.pop_front());
    end
  end

  task automatic set_query(input int r, input int c);
    qexp_t e;
    query_row = 3'(r);
    query_col = 3'(c);
    q_tag     = 1'b1;
    e.mine    = pad[r+1][c+1];
    e.count   = ref_counted ? 4'(ref_count(r, c)) : 4'd0;
    q_exp.push_back(e);
  endtask

  task automatic model_hs(input int r, input int c);
    if (!pad[r+1][c+1]) begin
      pad[r+1][c+1] = 1'b1;
      ref_placed++;
    end
    hs_exp.push_back(ref_placed);
  endtask

  task automatic start_game(input int total);
    q_tag       = 1'b0;
    cand_valid  = 1'b0;
    start       = 1'b1;
    total_mines = 4'(total);
    @(negedge clk);
    start = 1'b0;
    clear_model();
    ref_total = total;
    check("busy_after_start", int'(busy), 1);
    check("placed_after_start", int'(mines_placed), 0);
  endtask

  task automatic place(input int r, input int c);
    check("cand_ready_place", int'(cand_ready), 1);
    cand_valid = 1'b1;
    cand_row   = 3'(r);
    cand_col   = 3'(c);
    model_hs(r, c);
    @(negedge clk);
    cand_valid = 1'b0;
  endtask

  // Called on the first cycle after the final handshake (or after start with zero mines).
  task automatic wait_done(input int inject_at);
    int  nbusy  = 0;
    int  ncyc   = 0;
    bit  seen   = 1'b0;
    check("cand_ready_after_place", int'(cand_ready), 0);
    for (int k = 0; k < 200; k++) begin
      if (done) begin
        seen = 1'b1;
        break;
      end
      ncyc++;
      if (busy) nbusy++;
      if (k == inject_at) begin
        start       = 1'b1;
        total_mines = 4'd5;
      end else start = 1'b0;
      @(negedge clk);
    end
    start = 1'b0;
    if (!seen) check("done_timeout", 0, 1);
    check("cycles_to_done", ncyc, 64);
    check("busy_cycles", nbusy, 64);
    ref_counted = 1'b1;
  endtask

  task automatic dump_board();
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 8; c++) begin
        set_query(r, c);
        @(negedge clk);
      end
    q_tag = 1'b0;
    @(negedge clk);
    check("done_held", int'(done), 1);
  endtask

  task automatic random_game();
    int total;
    int r, c;
    total = int'($urandom_range(0, 15));
    start_game(total);
    while (ref_placed < ref_total) begin
      q_tag = 1'b0;
      check("cand_ready_rand", int'(cand_ready), 1);
      if ($urandom_range(0, 2) == 0) set_query(int'($urandom_range(0, 7)), int'($urandom_range(0, 7)));
      if ($urandom_range(0, 3) != 0) begin
        // Bias toward the top rows so duplicate candidates actually occur.
        r = ($urandom_range(0, 1) == 0) ? int'($urandom_range(0, 1)) : int'($urandom_range(0, 7));
        c = int'($urandom_range(0, 7));
        cand_valid = 1'b1;
        cand_row   = 3'(r);
        cand_col   = 3'(c);
        model_hs(r, c);
      end else cand_valid = 1'b0;
      @(negedge clk);
    end
    cand_valid = 1'b0;
    q_tag      = 1'b0;
    wait_done(-1);
    check("placed_final", int'(mines_placed), ref_total);
    dump_board();
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; start = 1'b0; total_mines = '0; cand_valid = 1'b0;
    cand_row = '0; cand_col = '0; query_row = '0; query_col = '0;
    clear_model();
    repeat (3) @(negedge clk);
    check("rst_cand_ready", int'(cand_ready), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_placed", int'(mines_placed), 0);
    check("rst_query_mine", int'(query_mine), 0);
    check("rst_query_count", int'(query_count), 0);
    rst = 1'b0;
    set_query(3, 4);
    @(negedge clk);
    q_tag = 1'b0;

    // Duplicate rejection and the corner example.
    start_game(3);
    place(0, 0); place(0, 0); place(1, 1); place(7, 7);
    wait_done(-1);
    set_query(0, 1); @(negedge clk);
    set_query(6, 6); @(negedge clk);
    set_query(7, 7); @(negedge clk);
    q_tag = 1'b0;
    dump_board();

    // Fully surrounded cell.
    start_game(8);
    for (int dr = -1; dr <= 1; dr++)
      for (int dc = -1; dc <= 1; dc++)
        if (dr != 0 || dc != 0) place(3 + dr, 3 + dc);
    wait_done(-1);
    dump_board();

    // Zero mines, with a start pulse during COUNT that must be ignored.
    start_game(0);
    wait_done(10);
    check("zero_placed", int'(mines_placed), 0);
    dump_board();

    // Reset mid-PLACE, colliding with a handshake.
    start_game(5);
    place(2, 2); place(4, 5);
    rst = 1'b1; cand_valid = 1'b1; cand_row = 3'd6; cand_col = 3'd6;
    @(negedge clk);
    rst = 1'b0; cand_valid = 1'b0;
    clear_model();
    check("abort_cand_ready", int'(cand_ready), 0);
    check("abort_busy", int'(busy), 0);
    check("abort_done", int'(done), 0);
    check("abort_placed", int'(mines_placed), 0);
    set_query(2, 2); @(negedge clk);
    q_tag = 1'b0; @(negedge clk);

    for (int g = 0; g < 20; g++) random_game();

    repeat (2) @(negedge clk);
    check("query_queue_empty", q_exp.size(), 0);
    check("handshake_queue_empty", hs_exp.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mine_board.md
MINE_BOARD -- requirements
Module: mine_board

Interface
REQ-001 Param: none; board fixed 8x8 via package constants ROWS=8, COLS=8.
REQ-002 clk  in  1  single clock; all logic rising-edge.
REQ-003 rst  in  1  synchronous, active-high reset.
REQ-004 start  in  1  pulse; begins a new game (clear board, accept placements).
REQ-005 total_mines  in  4  mines to place, latched on accepted start.
REQ-006 cand_valid  in  1  candidate coordinate present from random generator.
REQ-007 cand_row / cand_col  in  3 / 3  candidate mine position.
REQ-008 cand_ready  out  1  board accepts candidate this cycle.
REQ-009 query_row / query_col  in  3 / 3  cell to read.
REQ-010 query_mine  out  1  mine flag of queried cell, registered.
REQ-011 query_count  out  4  adjacent-mine count (0..8) of queried cell, registered.
REQ-012 mines_placed  out  4  mines placed so far this game.
REQ-013 busy  out  1  high in PLACE or COUNT.
REQ-014 done  out  1  high in DONE; board and counts valid.

Function
REQ-015 FSM states IDLE, PLACE, COUNT, DONE.
REQ-016 IDLE/DONE + start: next cycle PLACE; mine bits, counts, mines_placed cleared; total_mines latched.
REQ-017 start while busy ignored.
REQ-018 Latched total_mines=0: start goes directly to COUNT, skipping PLACE.
REQ-019 cand_ready = 1 only in PLACE; handshake = cand_valid & cand_ready.
REQ-020 Handshake on empty cell: set mine bit, mines_placed +1 next cycle.
REQ-021 Handshake on occupied cell: consumed, no change (duplicate rejection).
REQ-022 Handshake making mines_placed equal latched total: next state COUNT; cand_ready low from that next cycle.
REQ-023 COUNT: one cell per cycle, row-major index 0..63; count = mines in 3x3 window excluding center, out-of-board neighbours = 0 (no wrap).
REQ-024 COUNT lasts exactly 64 cycles, then DONE; done rises 65 cycles after final placement handshake.
REQ-025 Mine cells also get a count; query_mine distinguishes them.
REQ-026 Query outputs update one cycle after query_row/col sampled, in every state; counts not yet computed read 0.
REQ-027 mines_placed saturates at latched total; never exceeds 15.
REQ-028 DONE holds until start or rst.

Reset
REQ-029 rst: state IDLE, mine bits 0, all counts 0, mines_placed 0, cand_ready 0, busy 0, done 0, query_mine 0, query_count 0.
REQ-030 rst overrides start and handshake in same cycle; mid-game rst aborts and clears.

Structure
REQ-031 Package mine_pkg: ROWS, COLS, COORD_W=3, COUNT_W=4, state enum type.
REQ-032 Sub-module neighbor_counter: combinational, 64-bit mine vector + row/col in, 4-bit count out.
REQ-033 Mine storage 64-bit vector; counts 64x4 register array.

Verification
REQ-034 start, total_mines=3, candidates (0,0),(0,0),(1,1),(7,7) -> 2nd rejected, mines_placed 1,1,2,3; COUNT entered after (7,7).
REQ-035 mines at (0,0),(1,1),(7,7), after done: query (0,1) -> count 2, mine 0; (6,6) -> count 1; (7,7) -> mine 1, count 0.
REQ-036 total_mines=0, start -> busy 64 cycles, done at cycle 65, all counts 0.
REQ-037 Mines at all 8 neighbours of (3,3) -> query (3,3) count 8.
REQ-038 rst asserted mid-PLACE after 2 mines -> next cycle IDLE, mines_placed 0, cand_ready 0; start during COUNT ignored.
